// File: rtl/ru_result_merger_os.sv
// Result merger for the output-stationary array: captures a result matrix and
// the recomputed RU words, patches the faulty PEs, then streams rows out.
//
// Ports:
//   clk, rst (async, active-low)
//   sys_result_valid/sys_result_mat    full result matrix from the array
//   ru_en/ru_output_valid/ru_results   per-RU enable, pulse and result word
//   ru_row_mapping/ru_col_mapping      PE coordinates repaired by each RU
//   out_valid/out_ready/out_row_data/out_row_idx   row stream handshake
//   busy, frame_done, repaired_count, timeout_flag status
// Optional macro RU_MERGE_TIMEOUT_EN enables the COLLECT watchdog.
module ru_result_merger_os #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int WORD_SIZE      = 16,
  parameter int NUM_RU         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sys_result_valid,
  input  logic [ROWS*COLS*WORD_SIZE-1:0]    sys_result_mat,
  input  logic [NUM_RU-1:0]                 ru_en,
  input  logic [NUM_RU-1:0]                 ru_output_valid,
  input  logic [NUM_RU*WORD_SIZE-1:0]       ru_results,
  input  logic [$clog2(COLS)*NUM_RU-1:0]    ru_col_mapping,
  input  logic [$clog2(ROWS)*NUM_RU-1:0]    ru_row_mapping,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [COLS*WORD_SIZE-1:0]         out_row_data,
  output logic [$clog2(ROWS)-1:0]           out_row_idx,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(NUM_RU+1)-1:0]       repaired_count,
  output logic                              timeout_flag
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int NW  = $clog2(NUM_RU+1);
  localparam int MW  = ROWS*COLS*WORD_SIZE;
  localparam int RWD = COLS*WORD_SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PATCH,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [MW-1:0]             r_mat;
  logic                      r_mat_got;
  logic [NUM_RU-1:0]         r_ru_got;
  logic [NUM_RU*WORD_SIZE-1:0] r_ru_res;
  logic [RW*NUM_RU-1:0]      r_ru_row;
  logic [CW*NUM_RU-1:0]      r_ru_col;
  logic [RW-1:0]             r_idx;
  logic [NW-1:0]             r_cnt;
  logic                      r_done;

  logic                      w_capture;
  logic                      w_ru_ok;
  logic                      w_last;
  logic                      w_tfire;
  logic [MW-1:0]             w_patched;
  logic [NW-1:0]             w_cnt;

  assign w_capture = (r_state == S_IDLE) ||
                     (r_state == S_COLLECT);
  // ru_en is sampled live so a late disable still lets the frame exit
  assign w_ru_ok   = ((r_ru_got & ru_en) == ru_en);
  assign w_last    = (r_state == S_STREAM) && out_ready &&
                     (r_idx == RW'(ROWS-1));

  // Ascending loop: a later RU at the same coordinate overwrites earlier ones
  always_comb begin
    int rr;
    int cc;
    w_patched = r_mat;
    w_cnt     = '0;
    rr        = 0;
    cc        = 0;
    for (int i = 0; i < NUM_RU; i++) begin
      rr = int'(r_ru_row[i*RW +: RW]);
      cc = int'(r_ru_col[i*CW +: CW]);
      if (r_ru_got[i] && ru_en[i] &&
          (rr < ROWS) && (cc < COLS)) begin
        w_patched[(rr*COLS+cc)*WORD_SIZE +: WORD_SIZE] =
          r_ru_res[i*WORD_SIZE +: WORD_SIZE];
        w_cnt = w_cnt + NW'(1);
      end
    end
  end

`ifdef RU_MERGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] r_tcnt;
  logic          r_tout;

  assign w_tfire = (r_state == S_COLLECT) && r_mat_got &&
                   !w_ru_ok &&
                   (r_tcnt >= TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_tout <= 1'b0;
    end else begin
      if (r_state == S_IDLE)
        r_tcnt <= '0;
      else if (r_state == S_COLLECT &&
               r_tcnt != TW'(TIMEOUT_CYCLES))
        r_tcnt <= r_tcnt + TW'(1);
      if (w_tfire)
        r_tout <= 1'b1;
      else if (w_last)
        r_tout <= 1'b0;
    end
  end

  assign timeout_flag = r_tout;
`else
  logic w_unused_to;
  assign w_unused_to  = (TIMEOUT_CYCLES != 0);
  assign w_tfire      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (sys_result_valid || (|ru_output_valid))
          w_next = S_COLLECT;
      S_COLLECT:
        if ((r_mat_got && w_ru_ok) || w_tfire)
          w_next = S_PATCH;
      S_PATCH:
        w_next = S_STREAM;
      S_STREAM:
        if (w_last)
          w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid      = (r_state == S_STREAM);
    out_row_data   = '0;
    if (out_valid)
      out_row_data = r_mat[int'(r_idx)*RWD +: RWD];
    out_row_idx    = r_idx;
    busy           = (r_state != S_IDLE);
    frame_done     = r_done;
    repaired_count = r_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mat     <= '0;
      r_mat_got <= 1'b0;
      r_ru_got  <= '0;
      r_ru_res  <= '0;
      r_ru_row  <= '0;
      r_ru_col  <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_capture && sys_result_valid && !r_mat_got) begin
        r_mat     <= sys_result_mat;
        r_mat_got <= 1'b1;
      end
      if (w_capture) begin
        for (int i = 0; i < NUM_RU; i++) begin
          if (ru_output_valid[i]) begin
            r_ru_res[i*WORD_SIZE +: WORD_SIZE] <=
              ru_results[i*WORD_SIZE +: WORD_SIZE];
            r_ru_row[i*RW +: RW] <= ru_row_mapping[i*RW +: RW];
            r_ru_col[i*CW +: CW] <= ru_col_mapping[i*CW +: CW];
            r_ru_got[i] <= 1'b1;
          end
        end
      end
      if (r_state == S_IDLE && w_next == S_COLLECT)
        r_cnt <= '0;
      if (r_state == S_PATCH) begin
        r_mat <= w_patched;
        r_cnt <= w_cnt;
      end
      if (r_state == S_STREAM && out_ready) begin
        if (w_last) begin
          r_idx     <= '0;
          r_done    <= 1'b1;
          r_ru_got  <= '0;
          r_mat_got <= 1'b0;
        end else begin
          r_idx <= r_idx + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ru_result_merger_os.sv
// Scoreboard bench for ru_result_merger_os: directed frames with
// hand-built expected rows, checked by an independent monitor.
module tb_ru_result_merger_os;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_result_valid;
  logic [255:0] sys_result_mat;
  logic [3:0]  ru_en;
  logic [3:0]  ru_output_valid;
  logic [63:0] ru_results;
  logic [7:0]  ru_col_mapping;
  logic [7:0]  ru_row_mapping;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_row_data;
  logic [1:0]  out_row_idx;
  logic        busy;
  logic        frame_done;
  logic [2:0]  repaired_count;
  logic        timeout_flag;

  always #5 clk = ~clk;

  ru_result_merger_os #(
    .ROWS(4), .COLS(4), .WORD_SIZE(16),
    .NUM_RU(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sys_result_valid(sys_result_valid),
    .sys_result_mat(sys_result_mat),
    .ru_en(ru_en),
    .ru_output_valid(ru_output_valid),
    .ru_results(ru_results),
    .ru_col_mapping(ru_col_mapping),
    .ru_row_mapping(ru_row_mapping),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_row_data(out_row_data),
    .out_row_idx(out_row_idx),
    .busy(busy),
    .frame_done(frame_done),
    .repaired_count(repaired_count),
    .timeout_flag(timeout_flag)
  );

  typedef struct {
    logic [1:0]  idx;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          fd_cnt = 0;
  logic [15:0] m [4][4];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic        st_prev = 1'b0;
  logic [63:0] st_data;
  logic [1:0]  st_idx;

  always @(negedge clk) begin
    if (rst && st_prev) begin
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_data", out_row_data, st_data);
      chk("stall_idx", {62'b0, out_row_idx}, {62'b0, st_idx});
    end
    st_prev = rst && out_valid && !out_ready;
    st_data = out_row_data;
    st_idx  = out_row_idx;
    if (frame_done) fd_cnt++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_row: got idx %0d data %h expected none",
                 out_row_idx, out_row_data);
      end else begin
        mon_e = sb.pop_front();
        chk("row_idx", {62'b0, out_row_idx}, {62'b0, mon_e.idx});
        chk("row_data", out_row_data, mon_e.data);
      end
    end
  end

  task automatic set_mat(input logic [15:0] base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = base + 16'(r*4 + c);
  endtask

  task automatic push_rows();
    exp_t e;
    for (int r = 0; r < 4; r++) begin
      e.idx  = 2'(r);
      e.data = '0;
      for (int c = 0; c < 4; c++)
        e.data[c*16 +: 16] = m[r][c];
      sb.push_back(e);
    end
  endtask

  task automatic drive_mat();
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sys_result_mat[(r*4+c)*16 +: 16] = m[r][c];
    sys_result_valid = 1'b1;
    @(posedge clk); #1;
    sys_result_valid = 1'b0;
  endtask

  task automatic set_ru(input int i, input logic [15:0] v,
                        input logic [1:0] row, input logic [1:0] col);
    ru_results[i*16 +: 16]   = v;
    ru_row_mapping[i*2 +: 2] = row;
    ru_col_mapping[i*2 +: 2] = col;
  endtask

  task automatic pulse_ru(input logic [3:0] v);
    @(posedge clk); #1;
    ru_output_valid = v;
    @(posedge clk); #1;
    ru_output_valid = 4'b0;
  endtask

  task automatic wait_done(input string nm);
    int start;
    int k;
    start = fd_cnt;
    k = 0;
    while (fd_cnt == start && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk(nm, 64'(fd_cnt - start), 64'd1);
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {63'b0, out_valid}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    sys_result_valid = 1'b0;
    sys_result_mat = '0;
    ru_en = 4'b0;
    ru_output_valid = 4'b0;
    ru_results = '0;
    ru_col_mapping = '0;
    ru_row_mapping = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, frame_done}, 64'd0);
    chk("rst_count", {61'b0, repaired_count}, 64'd0);
    chk("rst_tflag", {63'b0, timeout_flag}, 64'd0);
    chk("rst_data", out_row_data, 64'd0);
    rst = 1'b1;

    // plain frame, checks latency
    set_mat(16'h0000);
    push_rows();
    drive_mat();
    @(negedge clk);
    chk("lat_collect_busy", {63'b0, busy}, 64'd1);
    chk("lat_collect_valid", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_patch_valid", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_stream_valid", {63'b0, out_valid}, 64'd1);
    chk("lat_stream_idx", {62'b0, out_row_idx}, 64'd0);
    wait_done("t1_done_once");
    chk("t1_count", {61'b0, repaired_count}, 64'd0);
    chk("t1_busy", {63'b0, busy}, 64'd0);

    // two RUs patched after the matrix
    ru_en = 4'b0011;
    set_ru(0, 16'hAAAA, 2'd1, 2'd2);
    set_ru(1, 16'h5555, 2'd3, 2'd0);
    set_mat(16'h0100);
    m[1][2] = 16'hAAAA;
    m[3][0] = 16'h5555;
    push_rows();
    set_mat(16'h0100);
    drive_mat();
    pulse_ru(4'b0001);
    repeat (5) @(negedge clk);
    chk("t2_wait_valid", {63'b0, out_valid}, 64'd0);
    chk("t2_wait_busy", {63'b0, busy}, 64'd1);
    pulse_ru(4'b0010);
    wait_done("t2_done_once");
    chk("t2_count", {61'b0, repaired_count}, 64'd2);

    // duplicate coordinates: higher RU wins
    ru_en = 4'b0101;
    set_ru(0, 16'h1111, 2'd0, 2'd0);
    set_ru(2, 16'h2222, 2'd0, 2'd0);
    set_mat(16'h0200);
    m[0][0] = 16'h2222;
    push_rows();
    set_mat(16'h0200);
    drive_mat();
    pulse_ru(4'b0101);
    wait_done("t3_done_once");
    chk("t3_count", {61'b0, repaired_count}, 64'd2);

    // RU pulse arrives in IDLE, matrix later
    ru_en = 4'b0001;
    set_ru(0, 16'hBEEF, 2'd2, 2'd3);
    set_mat(16'h0300);
    m[2][3] = 16'hBEEF;
    push_rows();
    set_mat(16'h0300);
    pulse_ru(4'b0001);
    drive_mat();
    wait_done("t4_done_once");
    chk("t4_count", {61'b0, repaired_count}, 64'd1);

    // backpressure: stall row 1 for 3 cycles
    ru_en = 4'b0000;
    out_ready = 1'b0;
    set_mat(16'h0400);
    push_rows();
    drive_mat();
    wait_valid("t5_valid");
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("t5_done_once");

    // reset in the middle of a stream
    out_ready = 1'b0;
    set_mat(16'h0500);
    drive_mat();
    wait_valid("t6_valid");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("t6_rst_busy", {63'b0, busy}, 64'd0);
    chk("t6_rst_idx", {62'b0, out_row_idx}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    set_mat(16'h0600);
    push_rows();
    drive_mat();
    wait_done("t7_done_once");
    chk("t7_count", {61'b0, repaired_count}, 64'd0);

`ifdef RU_MERGE_TIMEOUT_EN
    // enabled RU never reports: watchdog releases the frame
    ru_en = 4'b0001;
    set_mat(16'h0700);
    push_rows();
    drive_mat();
    wait_valid("t8_valid");
    chk("t8_tflag_on", {63'b0, timeout_flag}, 64'd1);
    wait_done("t8_done_once");
    chk("t8_tflag_off", {63'b0, timeout_flag}, 64'd0);
    chk("t8_count", {61'b0, repaired_count}, 64'd0);
    ru_en = 4'b0000;
`else
    chk("tflag_tied", {63'b0, timeout_flag}, 64'd0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
